alu_operand_rf: RTL
===================

Name: alu_operand_rf

Overview:
Register file plus operand-issue stage that sits directly upstream of the alu and drives its src1/src2 inputs. It also accepts the alu result back as a write-back, and it captures the alu zero/cout/overflow flags into a flag register.
- 32 x 32-bit registers: two read ports, one write port.
- Read ports have one-cycle registered latency, so operands arrive aligned with a registered valid.

Parameters:
DATA_W, 32, register and operand width
ADDR_W, 5, register address width
DEPTH, 32, number of registers (2**ADDR_W)
SP_IDX, 29, index of register with non-zero reset value
SP_INIT, 32'd128, reset value of register SP_IDX

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset; synchronous, active-low
rd_req  in  1  issue request: latch a read of rs1_addr/rs2_addr
rs1_addr  in  ADDR_W  src1 register index
rs2_addr  in  ADDR_W  src2 register index
src1  out  DATA_W  registered operand 1 to alu src1
src2  out  DATA_W  registered operand 2 to alu src2
src_valid  out  1  src1/src2 hold data for the request issued last cycle
wr_en  in  1  write-back enable
wr_addr  in  ADDR_W  write-back register index
wr_data  in  DATA_W  write-back data (alu result)
flag_we  in  1  capture alu flags
zcv_in  in  3  {zero, cout, overflow} from alu
zcv_q  out  3  captured flags

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is synchronous and active-low. With rst_n=0 at a rising edge:
  - all registers clear to 0, except reg[SP_IDX] which loads SP_INIT.
  - src1, src2, zcv_q clear to 0; src_valid clears to 0.
  - wr_en, rd_req and flag_we in the same cycle are ignored.
- Register 0 is hardwired to 0. Writes to it are discarded, and reads of it always return 0, including through the bypass path.
- Write: at the rising edge with wr_en=1 and rst_n=1, reg[wr_addr] <= wr_data. A write takes effect at that edge.
- Read: at the rising edge with rd_req=1:
  - src1 <= value(rs1_addr), src2 <= value(rs2_addr), src_valid <= 1.
  - Latency is exactly 1 cycle.
- With rd_req=0: src1 and src2 hold their previous values, and src_valid <= 0.
- Back-to-back rd_req every cycle is legal: one result per cycle, no stalls.
- Same-edge read/write to the same non-zero address: the returned value is defined under Optional Feature.
- rs1_addr == rs2_addr is legal: both ports return the same value.
- Flags: at the edge with flag_we=1, zcv_q <= zcv_in. Otherwise zcv_q holds. zcv_q is independent of the read/write paths.
- Reset mid-stream: a request issued in the reset cycle is lost, and src_valid is 0 in the following cycle.
- No X propagation: all outputs are defined from the first reset edge onward.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: write-to-read forwarding. If wr_en=1 and rd_req=1 at the same edge with wr_addr == rsN_addr != 0, srcN <= wr_data, i.e. the new value.
- Undefined: srcN <= the pre-write register contents, i.e. the old value. The write still completes.
- Register 0 returns 0 in both builds.

Decomposition:
- Shared package alu_pkg, holding:
  - DATA_W and ADDR_W constants.
  - the ZCV bit indices: Z=2, C=1, V=0.
  - the alu opcode constants AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12, NAND=13.
  - the bonus compare codes SLT=0, SGT=1, SLE=2, SGE=3, SNE=4, SEQ=6.
- One natural sub-module: rf_core. It holds the storage array, the write port and the combinational raw read muxes with the reg-0 rule. The top adds the bypass, the output registers, the valid and the flag register.

Test Plan:
- Reset: hold rst_n=0 for 2 edges, then rd_req with rs1=29, rs2=5 -> next cycle src1=32'h00000080, src2=0, src_valid=1.
- Write/read: wr_en, wr_addr=3, wr_data=32'hDEADBEEF; next cycle rd_req rs1=3 rs2=0 -> src1=32'hDEADBEEF, src2=0, src_valid=1 one cycle after rd_req.
- Reg 0: write 32'hFFFFFFFF to addr 0, then read rs1=0 -> src1=0 in both builds.
- Same-edge hazard: reg7=32'h1, then wr_en addr7 data 32'h2 together with rd_req rs1=7 -> src1=32'h2 with RF_BYPASS_EN, 32'h1 without; a following read returns 32'h2.
- Flags: flag_we=1, zcv_in=3'b101 -> zcv_q=3'b101 next cycle; flag_we=0, zcv_in=3'b010 -> zcv_q stays 3'b101.
- Mid-stream reset: rd_req each cycle; drop rst_n for one edge -> src_valid=0 the cycle after, previously written registers read back 0, reg29 reads back 32'h80.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared alu definitions: datapath widths, flag bit positions, opcode and compare codes.
package alu_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam int ZCV_Z = 2;
   localparam int ZCV_C = 1;
   localparam int ZCV_V = 0;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd7;
   localparam logic [3:0] OP_NOR  = 4'd12;
   localparam logic [3:0] OP_NAND = 4'd13;

   localparam logic [2:0] CMP_SLT = 3'd0;
   localparam logic [2:0] CMP_SGT = 3'd1;
   localparam logic [2:0] CMP_SLE = 3'd2;
   localparam logic [2:0] CMP_SGE = 3'd3;
   localparam logic [2:0] CMP_SNE = 3'd4;
   localparam logic [2:0] CMP_SEQ = 3'd6;
endpackage

// File: rtl/rf_core.sv
// Register storage with one write port and two combinational raw read ports.
// Register 0 reads as zero and ignores writes; one register resets to a non-zero value.
module rf_core
   import alu_pkg::*;
#(
   parameter int                DEPTH   = 32,
   parameter int                SP_IDX  = 29,
   parameter logic [DATA_W-1:0] SP_INIT = 32'd128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0] rd1_data,
   output logic [DATA_W-1:0] rd2_data
);
   logic [DATA_W-1:0] regs_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
      rd2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
   end
endmodule

// File: rtl/alu_operand_rf.sv
// Operand-issue stage: register file, registered src1/src2 with valid (1 cycle), alu flag register.
// RF_BYPASS_EN selects same-edge write-to-read forwarding; otherwise reads see pre-write contents.
module alu_operand_rf
   import alu_pkg::*;
#(
   parameter int                DEPTH   = 32,
   parameter int                SP_IDX  = 29,
   parameter logic [DATA_W-1:0] SP_INIT = 32'd128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0] src1,
   output logic [DATA_W-1:0] src2,
   output logic              src_valid,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              flag_we,
   input  logic [2:0]        zcv_in,
   output logic [2:0]        zcv_q
);
   logic [DATA_W-1:0] rd1_raw, rd2_raw;
   logic [DATA_W-1:0] src1_d, src2_d, src1_q, src2_q;
   logic              valid_q;
   logic [2:0]        zcv_r_q;

   rf_core #(
      .DEPTH  (DEPTH),
      .SP_IDX (SP_IDX),
      .SP_INIT(SP_INIT)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rs1_addr(rs1_addr),
      .rs2_addr(rs2_addr),
      .rd1_data(rd1_raw),
      .rd2_data(rd2_raw)
   );

`ifdef RF_BYPASS_EN
   // Forward only non-zero targets so register 0 still reads as zero.
   always_comb begin
      src1_d = (wr_en && (wr_addr == rs1_addr) && (rs1_addr != '0)) ? wr_data : rd1_raw;
      src2_d = (wr_en && (wr_addr == rs2_addr) && (rs2_addr != '0)) ? wr_data : rd2_raw;
   end
`else
   always_comb begin
      src1_d = rd1_raw;
      src2_d = rd2_raw;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         src1_q  <= '0;
         src2_q  <= '0;
         valid_q <= 1'b0;
         zcv_r_q <= '0;
      end else begin
         if (rd_req) begin
            src1_q <= src1_d;
            src2_q <= src2_d;
         end
         valid_q <= rd_req;
         if (flag_we) begin
            zcv_r_q <= zcv_in;
         end
      end
   end

   assign src1      = src1_q;
   assign src2      = src2_q;
   assign src_valid = valid_q;
   assign zcv_q     = zcv_r_q;
endmodule
